// File: rtl/nes_frame_scaler_if.sv
// PPU pixel-write port and llhdmi pixel-pull port of the NES frame scaler.
interface nes_frame_scaler_if;
   logic        i_ppu_we;
   logic [7:0]  i_ppu_x;
   logic [7:0]  i_ppu_y;
   logic [5:0]  i_ppu_idx;
   logic        i_rd;
   logic        i_newline;
   logic        i_newframe;
   logic [23:0] o_pixel;
   logic        o_underflow;

   modport master (
      output i_ppu_we, i_ppu_x, i_ppu_y, i_ppu_idx, i_rd, i_newline, i_newframe,
      input  o_pixel, o_underflow
   );

   modport slave (
      input  i_ppu_we, i_ppu_x, i_ppu_y, i_ppu_idx, i_rd, i_newline, i_newframe,
      output o_pixel, o_underflow
   );
endinterface

// File: rtl/nes_frame_scaler.sv
// NES framebuffer plus 2x scaler feeding the llhdmi pull interface at 640x480.
// A feeder issues reads into a 2-stage pipeline (BRAM, palette) that fills a
// 4-entry prefetch FIFO; llhdmi pops pixels from the FIFO head.
module nes_frame_scaler #(
   parameter logic [23:0] BORDER_RGB   = 24'h000000,
   parameter int          H_OFFSET     = 64,
   parameter              PALETTE_FILE = "nes_palette.hex"
) (
   input logic               clk_25MHz,
   input logic               rst,
   nes_frame_scaler_if.slave bus
);

   // The contents of nes_palette.hex are held as a constant table.
   if (PALETTE_FILE != "nes_palette.hex") begin : g_palette_check
      $error("nes_frame_scaler: only the built-in nes_palette.hex table is available");
   end

   localparam logic [23:0] PALETTE [64] = '{
      24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
      24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
      24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
      24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
      24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
      24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
      24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
   };

   localparam logic [9:0] LINE_COLS = 10'd640;
   localparam logic [8:0] ROW_LIMIT = 9'd480;
   localparam logic [9:0] H_START   = 10'(H_OFFSET);
   localparam logic [9:0] H_END     = 10'(H_OFFSET + 512);

   logic [5:0]  fb_mem [0:61439];

   logic [8:0]  row;
   logic [8:0]  row_next;
   logic [9:0]  col;
   logic [9:0]  popped;
   logic        epoch;
   logic        underflow;

   logic        vld_p0;
   logic        border_p0;
   logic [15:0] addr_p0;

   logic        vld_p1;
   logic        border_p1;
   logic        epoch_p1;
   logic [5:0]  idx_p1;
   logic        live_p1;

   logic        vld_p2;
   logic [23:0] rgb_p2;

   logic [23:0] fifo_mem [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;
   logic        pop;

   // Feeder issue decision, palette stage and FIFO pop, all combinational.
   always_comb begin
      live_p1   = vld_p1 && (epoch_p1 == epoch);
      vld_p0    = !bus.i_newline && (col < LINE_COLS) && ((count + {2'b00, live_p1}) < 3'd4);
      border_p0 = !((col >= H_START) && (col < H_END) && (row < ROW_LIMIT));
      addr_p0   = {row[8:1], 8'((col - H_START) >> 1)};
      vld_p2    = live_p1 && !bus.i_newline;
      rgb_p2    = border_p1 ? BORDER_RGB : PALETTE[idx_p1];
      pop       = bus.i_rd && !bus.i_newline && (count != 3'd0);
   end

   // ---- stage 0 -> 1: framebuffer write port and read port (read-old-data) ----
   always_ff @(posedge clk_25MHz) begin
      if (bus.i_ppu_we && (bus.i_ppu_y < 8'd240))
         fb_mem[{bus.i_ppu_y, bus.i_ppu_x}] <= bus.i_ppu_idx;
      if (vld_p0 && !border_p0)
         idx_p1 <= fb_mem[addr_p0];
   end

   // Stage-1 tags travelling with the BRAM read.
   always_ff @(posedge clk_25MHz) begin
      border_p1 <= border_p0;
      epoch_p1  <= epoch;
   end

   // Stage-1 valid.
   always_ff @(posedge clk_25MHz) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= vld_p0;
   end

   // Row/column tracking, line epoch and the sticky underflow flag.
   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         row       <= ROW_LIMIT;
         row_next  <= 9'd0;
         col       <= LINE_COLS;
         popped    <= LINE_COLS;
         epoch     <= 1'b0;
         underflow <= 1'b0;
      end else if (bus.i_newline) begin
         row      <= bus.i_newframe ? 9'd0 : row_next;
         row_next <= bus.i_newframe ? 9'd1 :
                     (row_next == ROW_LIMIT) ? ROW_LIMIT : row_next + 9'd1;
         col      <= 10'd0;
         popped   <= 10'd0;
         epoch    <= ~epoch;
      end else begin
         if (bus.i_newframe) row_next <= 9'd0;
         if (vld_p0)         col      <= col + 10'd1;
         if (pop)            popped   <= popped + 10'd1;
         if (bus.i_rd && (count == 3'd0) && (popped < LINE_COLS))
            underflow <= 1'b1;
      end
   end

   // ---- stage 2 -> FIFO: pointer and occupancy control, flushed by newline ----
   always_ff @(posedge clk_25MHz) begin
      if (rst || bus.i_newline) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (vld_p2) wr_ptr <= wr_ptr + 2'd1;
         if (pop)    rd_ptr <= rd_ptr + 2'd1;
         count <= count + 3'(vld_p2) - 3'(pop);
      end
   end

   // FIFO storage.
   always_ff @(posedge clk_25MHz) begin
      if (vld_p2) fifo_mem[wr_ptr] <= rgb_p2;
   end

   assign bus.o_pixel     = (count != 3'd0) ? fifo_mem[rd_ptr] : BORDER_RGB;
   assign bus.o_underflow = underflow;

endmodule

// File: tb/tb_nes_frame_scaler.sv
// Scoreboard bench for nes_frame_scaler: a display-level model computes each
// consumed pixel from the NES frame contents; a monitor compares on every pop.
module tb_nes_frame_scaler;

   localparam logic [23:0] BORDER = 24'h0A0B0C;

   logic clk_25MHz = 1'b0;
   logic rst;

   always #20 clk_25MHz = ~clk_25MHz;

   nes_frame_scaler_if bus ();

   nes_frame_scaler #(
      .BORDER_RGB  (BORDER),
      .H_OFFSET    (64),
      .PALETTE_FILE("nes_palette.hex")
   ) dut (
      .clk_25MHz(clk_25MHz),
      .rst      (rst),
      .bus      (bus)
   );

   typedef struct {
      int          row;
      int          col;
      logic [23:0] rgb;
   } exp_t;

   logic [5:0] ref_fb [0:239][0:255];
   exp_t       exp_q [$];
   int         cur_row;
   int         next_row;
   int         checks = 0;
   int         errors = 0;

   function automatic logic [23:0] nes_rgb(logic [5:0] idx);
      return (idx == 6'h30) ? 24'hFFFFFF : 24'h000000;
   endfunction

   // Display pixel (r, c) of the 640x480 picture.
   function automatic logic [23:0] expect_px(int r, int c);
      if (r >= 480 || c < 64 || c >= 576) return BORDER;
      return nes_rgb(ref_fb[r / 2][(c - 64) / 2]);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk_25MHz);
      #1;
   endtask

   task automatic ppu_write(int x, int y, logic [5:0] idx);
      bus.i_ppu_we  = 1'b1;
      bus.i_ppu_x   = 8'(x);
      bus.i_ppu_y   = 8'(y);
      bus.i_ppu_idx = idx;
      if (y < 240) ref_fb[y][x] = idx;
      tick();
      bus.i_ppu_we = 1'b0;
   endtask

   // mode 0: whole row = idx; mode 1: random mix of black and white
   task automatic fill_row(int y, logic [5:0] idx, bit rand_mode);
      for (int x = 0; x < 256; x++)
         ppu_write(x, y, rand_mode ? (($urandom_range(0, 1) == 1) ? 6'h30 : 6'h0F) : idx);
   endtask

   task automatic newline(bit frame);
      bus.i_newline  = 1'b1;
      bus.i_newframe = frame;
      cur_row  = frame ? 0 : next_row;
      next_row = (cur_row + 1 > 480) ? 480 : cur_row + 1;
      tick();
      bus.i_newline  = 1'b0;
      bus.i_newframe = 1'b0;
   endtask

   // Consume n pixels of the current line, starting 4 cycles after newline.
   task automatic play(int n, int max_gap);
      repeat (3) tick();
      for (int c = 0; c < n; c++) begin
         exp_q.push_back('{row: cur_row, col: c, rgb: expect_px(cur_row, c)});
         bus.i_rd = 1'b1;
         tick();
         bus.i_rd = 1'b0;
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cur_row  = 480;
      next_row = 0;
   endtask

   // Monitor: every consumed pixel is compared with the scoreboard head.
   always @(negedge clk_25MHz) begin
      if (!rst && bus.i_rd && !bus.i_newline) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pixel_unexpected: got %h, expected no read", bus.o_pixel);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("pixel_r%0d_c%0d", e.row, e.col), 32'(bus.o_pixel), 32'(e.rgb));
         end
      end
   end

   initial begin
      #3600000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.i_ppu_we   = 1'b0;
      bus.i_ppu_x    = 8'd0;
      bus.i_ppu_y    = 8'd0;
      bus.i_ppu_idx  = 6'd0;
      bus.i_rd       = 1'b0;
      bus.i_newline  = 1'b0;
      bus.i_newframe = 1'b0;
      rst            = 1'b1;
      cur_row        = 480;
      next_row       = 0;
      repeat (3) tick();
      check("reset_pixel", 32'(bus.o_pixel), 32'(BORDER));
      check("reset_underflow", 32'(bus.o_underflow), 32'd0);
      rst = 1'b0;
      tick();

      // Full-white row, two display rows back to back.
      fill_row(0, 6'h30, 1'b0);
      newline(1'b1);
      play(640, 0);
      newline(1'b0);
      play(640, 0);
      check("t1_underflow", 32'(bus.o_underflow), 32'd0);

      // Single white pixel at the top-left of a black frame.
      fill_row(0, 6'h0F, 1'b0);
      fill_row(1, 6'h0F, 1'b0);
      ppu_write(0, 0, 6'h30);
      newline(1'b1);
      play(640, 0);
      for (int i = 0; i < 2; i++) begin
         newline(1'b0);
         play(640, 0);
      end

      // Random content, random gaps between pops.
      for (int y = 2; y < 6; y++) fill_row(y, 6'h0F, 1'b1);
      for (int i = 0; i < 7; i++) begin
         newline(1'b0);
         play(640, 2);
      end
      check("rand_underflow", 32'(bus.o_underflow), 32'd0);

      // Newline mid-line (with a colliding pop) flushes pre-fetched pixels.
      newline(1'b0);
      play(300, 0);
      bus.i_rd = 1'b1;
      newline(1'b0);
      bus.i_rd = 1'b0;
      play(640, 0);

      // Out-of-frame PPU write is ignored; bottom-right corner and row 480.
      ppu_write(0, 240, 6'h30);
      fill_row(239, 6'h0F, 1'b0);
      ppu_write(255, 239, 6'h30);
      newline(1'b1);
      play(640, 0);
      while (cur_row < 478) begin
         newline(1'b0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         newline(1'b0);
         play(640, 0);
      end
      check("bottom_underflow", 32'(bus.o_underflow), 32'd0);

      // Early pop right after newline: sticky underflow.
      do_reset();
      newline(1'b0);
      exp_q.push_back('{row: cur_row, col: -1, rgb: BORDER});
      bus.i_rd = 1'b1;
      tick();
      bus.i_rd = 1'b0;
      tick();
      check("underflow_set", 32'(bus.o_underflow), 32'd1);
      play(640, 0);
      newline(1'b0);
      repeat (5) tick();
      check("underflow_sticky", 32'(bus.o_underflow), 32'd1);
      do_reset();
      check("underflow_cleared", 32'(bus.o_underflow), 32'd0);

      // Over-read past column 639.
      newline(1'b0);
      play(650, 0);
      check("overread_underflow", 32'(bus.o_underflow), 32'd0);

      // Reset in the middle of a line with a full FIFO and underflow set.
      newline(1'b0);
      exp_q.push_back('{row: cur_row, col: -1, rgb: BORDER});
      bus.i_rd = 1'b1;
      tick();
      bus.i_rd = 1'b0;
      play(200, 0);
      repeat (4) tick();
      check("midline_underflow_before_rst", 32'(bus.o_underflow), 32'd1);
      do_reset();
      check("midline_rst_pixel", 32'(bus.o_pixel), 32'(BORDER));
      check("midline_rst_underflow", 32'(bus.o_underflow), 32'd0);

      // Recovery after reset.
      newline(1'b1);
      play(640, 1);

      repeat (4) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
